// File: rtl/mbist_fail_log_if.sv
// Bus between the MBIST controller/diagnosis host and the failure log:
// fail capture, start/done control, indexed read-out and log status.
interface mbist_fail_log_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int IDX_W = $clog2(DEPTH) + 1;

    logic              start;
    logic              fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_syn;
    logic              done;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_valid;
    logic              rd_hit;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_syn;
    logic [IDX_W-1:0]  entries;
    logic [7:0]        fail_count;
    logic              overflow;
    logic              report_ready;

    modport master (
        output start, fail, fail_addr, fail_syn, done, rd_en, rd_idx,
        input  rd_valid, rd_hit, rd_addr, rd_syn, entries, fail_count,
               overflow, report_ready
    );

    modport slave (
        input  start, fail, fail_addr, fail_syn, done, rd_en, rd_idx,
        output rd_valid, rd_hit, rd_addr, rd_syn, entries, fail_count,
               overflow, report_ready
    );
endinterface

// File: rtl/mbist_fail_log.sv
// MBIST failure log: merges repeat hits per address, keeps unique failing words,
// a saturating fail count and overflow flag; frozen for read-out after done.
module mbist_fail_log #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input logic             clk,
    input logic             rst,
    mbist_fail_log_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOG    = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              capture;
    logic              report_ready;

    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_syn  [DEPTH];
    logic [DEPTH-1:0]  ent_vld;
    logic [IDX_W-1:0]  entries;
    logic [7:0]        fail_count;
    logic              overflow;

    logic [DEPTH-1:0]  match_vec;
    logic [DEPTH-1:0]  slot_vec;
    logic              hit_any;
    logic              full;
    logic              append;

    logic              sel_hit;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_syn;
    logic              vld_p1;
    logic              hit_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] syn_p1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end
        return v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        capture      = 1'b0;
        report_ready = 1'b0;
        if (bus.start) begin
            state_nxt = LOG;
        end else if (state == LOG && bus.done) begin
            state_nxt = REPORT;
        end
        // A fail coincident with start is dropped; a fail with done is still logged.
        if (state == LOG && bus.fail && !bus.start) begin
            capture = 1'b1;
        end
        if (state == REPORT) begin
            report_ready = 1'b1;
        end
    end

    // Parallel compare against every valid entry; slot_vec marks the append slot.
    always_comb begin
        match_vec = '0;
        slot_vec  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = ent_vld[i] && (ent_addr[i] == bus.fail_addr);
            slot_vec[i]  = (entries == IDX_W'(i));
        end
    end

    assign hit_any = |match_vec;
    assign full    = (entries == IDX_W'(DEPTH));
    assign append  = capture && !hit_any && !full;

    always_ff @(posedge clk) begin
        if (!rst || bus.start) begin
            entries    <= '0;
            fail_count <= '0;
            overflow   <= 1'b0;
            ent_vld    <= '0;
        end else if (capture) begin
            fail_count <= sat_inc(fail_count);
            if (append) begin
                entries <= entries + IDX_W'(1);
                ent_vld <= ent_vld | slot_vec;
            end else if (!hit_any) begin
                overflow <= 1'b1;
            end
        end
    end

    // Entry payload carries no reset; ent_vld alone qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (capture) begin
                if (match_vec[i]) begin
                    ent_syn[i] <= ent_syn[i] | bus.fail_syn;
                end else if (append && slot_vec[i]) begin
                    ent_addr[i] <= bus.fail_addr;
                    ent_syn[i]  <= bus.fail_syn;
                end
            end
        end
    end

    always_comb begin
        sel_hit  = (bus.rd_idx < entries);
        sel_addr = '0;
        sel_syn  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_hit && bus.rd_idx == IDX_W'(i)) begin
                sel_addr = ent_addr[i];
                sel_syn  = ent_syn[i];
            end
        end
    end

    // Read-out stage boundary: one-cycle registered result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            hit_p1  <= 1'b0;
            addr_p1 <= '0;
            syn_p1  <= '0;
        end else begin
            vld_p1  <= bus.rd_en;
            hit_p1  <= bus.rd_en && sel_hit;
            addr_p1 <= bus.rd_en ? sel_addr : '0;
            syn_p1  <= bus.rd_en ? sel_syn : '0;
        end
    end

    assign bus.rd_valid     = vld_p1;
    assign bus.rd_hit       = hit_p1;
    assign bus.rd_addr      = addr_p1;
    assign bus.rd_syn       = syn_p1;
    assign bus.entries      = entries;
    assign bus.fail_count   = fail_count;
    assign bus.overflow     = overflow;
    assign bus.report_ready = report_ready;
endmodule

// File: tb/tb_mbist_fail_log.sv
// Scoreboard bench for mbist_fail_log: directed scenarios plus random traffic
// checked against a queue-based model of the failure log.
module tb_mbist_fail_log;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    typedef struct {
        int         tag;
        logic [2:0] ent;
        logic [7:0] cnt;
        logic       ovf;
        logic       rr;
        logic       zero_rd;
    } st_t;

    typedef struct {
        int         tag;
        logic       hit;
        logic [2:0] a;
        logic [7:0] s;
    } rd_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_pass;
    int   n_total;

    st_t stq[$];
    rd_t rdq[$];

    // Reference model: mode 0 idle, 1 logging, 2 reporting.
    int         m_mode;
    logic [2:0] m_addr[$];
    logic [7:0] m_syn[$];
    int         m_cnt;
    bit         m_ovf;

    mbist_fail_log_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    mbist_fail_log #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic m_clear();
        m_addr.delete();
        m_syn.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic step(input logic r, input logic st, input logic f,
                        input logic [2:0] a, input logic [7:0] s,
                        input logic d, input logic re, input logic [2:0] idx);
        st_t e;
        rd_t q;
        int  pos;
        rst           = r;
        bus.start     = st;
        bus.fail      = f;
        bus.fail_addr = a;
        bus.fail_syn  = s;
        bus.done      = d;
        bus.rd_en     = re;
        bus.rd_idx    = idx;
        e.zero_rd     = 1'b0;
        if (!r) begin
            m_mode    = 0;
            m_clear();
            e.zero_rd = 1'b1;
        end else begin
            if (re) begin
                q.tag = cyc + 1;
                if (int'(idx) < m_addr.size()) begin
                    q.hit = 1'b1;
                    q.a   = m_addr[idx];
                    q.s   = m_syn[idx];
                end else begin
                    q.hit = 1'b0;
                    q.a   = '0;
                    q.s   = '0;
                end
                rdq.push_back(q);
            end
            if (st) begin
                m_mode = 1;
                m_clear();
            end else if (m_mode == 1) begin
                if (f) begin
                    if (m_cnt < 255) m_cnt++;
                    pos = -1;
                    foreach (m_addr[j]) if (m_addr[j] == a) pos = j;
                    if (pos >= 0) begin
                        m_syn[pos] = m_syn[pos] | s;
                    end else if (m_addr.size() < DEPTH) begin
                        m_addr.push_back(a);
                        m_syn.push_back(s);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (d) m_mode = 2;
            end
        end
        e.tag = cyc + 1;
        e.ent = 3'(m_addr.size());
        e.cnt = 8'(m_cnt);
        e.ovf = m_ovf;
        e.rr  = (m_mode == 2);
        stq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic fl(input logic [2:0] a, input logic [7:0] s);
        step(1'b1, 1'b0, 1'b1, a, s, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic rd(input logic [2:0] idx);
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, idx);
    endtask

    task automatic go();
        step(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic fin();
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd0);
    endtask

    // Monitor: status every checked cycle, read result whenever one is due.
    always @(negedge clk) begin : monitor
        st_t s;
        rd_t r;
        if (stq.size() != 0 && stq[0].tag == cyc) begin
            s = stq.pop_front();
            chk("entries", 32'(bus.entries), 32'(s.ent));
            chk("fail_count", 32'(bus.fail_count), 32'(s.cnt));
            chk("overflow", 32'(bus.overflow), 32'(s.ovf));
            chk("report_ready", 32'(bus.report_ready), 32'(s.rr));
            if (s.zero_rd) begin
                chk("rst_rd_hit", 32'(bus.rd_hit), 32'd0);
                chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
                chk("rst_rd_syn", 32'(bus.rd_syn), 32'd0);
            end
            if (rdq.size() != 0 && rdq[0].tag == cyc) begin
                r = rdq.pop_front();
                chk("rd_valid", 32'(bus.rd_valid), 32'd1);
                chk("rd_hit", 32'(bus.rd_hit), 32'(r.hit));
                chk("rd_addr", 32'(bus.rd_addr), 32'(r.a));
                chk("rd_syn", 32'(bus.rd_syn), 32'(r.s));
            end else begin
                chk("rd_valid_idle", 32'(bus.rd_valid), 32'd0);
            end
        end
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_mode  = 0;
        m_clear();
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.fail      = 1'b0;
        bus.fail_addr = '0;
        bus.fail_syn  = '0;
        bus.done      = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_idx    = '0;
        @(posedge clk);
        #1;

        // Reset, then a fail in IDLE must be ignored.
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0);
        fl(3'd2, 8'h55);
        rd(3'd0);
        idle(2);

        // Merge of back-to-back hits on one address.
        go();
        fl(3'd4, 8'h04);
        fl(3'd4, 8'h10);
        fin();
        rd(3'd0);
        rd(3'd1);
        idle(1);

        // Fill and overflow.
        go();
        fl(3'd0, 8'h01);
        fl(3'd1, 8'h01);
        fl(3'd2, 8'h01);
        fl(3'd3, 8'h01);
        fl(3'd5, 8'h01);
        fin();
        for (int i = 0; i < 5; i++) rd(3'(4 - i));
        idle(1);

        // Fail coincident with done, then a fail in REPORT.
        go();
        step(1'b1, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 3'd0);
        rd(3'd0);
        fl(3'd1, 8'hFF);
        rd(3'd1);
        idle(1);

        // Saturation and restart; start coincident with a fail drops it.
        go();
        for (int i = 0; i < 300; i++) fl(3'd1, 8'(1 << (i % 8)));
        rd(3'd0);
        step(1'b1, 1'b1, 1'b1, 3'd6, 8'h22, 1'b0, 1'b0, 3'd0);
        fl(3'd6, 8'h01);
        idle(1);

        // Reset the cycle after a REPORT read.
        go();
        fl(3'd2, 8'h0F);
        fin();
        rd(3'd0);
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd0);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step(1'b1 ^ ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 2) != 0),
                 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 1) == 1),
                 3'($urandom_range(0, 7)));
        end
        idle(3);

        for (int i = 0; i < 5 && (stq.size() != 0 || rdq.size() != 0); i++) @(negedge clk);
        n_total++;
        if (stq.size() != 0 || rdq.size() != 0) begin
            $display("FAIL drain: %0d status and %0d read expectations left, expected 0",
                     stq.size(), rdq.size());
        end else begin
            n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
